sap_memory_unit: RTL
====================

Name: sap_memory_unit

Overview:
- Memory stage directly downstream of the SAP-1 control logic: the memory address register (MAR) plus a 16x8 RAM.
- Consumes the maddr_latch, ram_latch and ram_out control strobes and drives RAM contents onto the shared 8-bit bus.
- Zero-fills RAM after reset.
- Provides a valid/ready programming port so a host can load a program before or between runs.

Parameters:
- ADDR_W, 4, address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, data and bus width.

Ports:
- clk  in  1  system clock; all state updates on posedge (control logic updates on negedge).
- reset  in  1  synchronous, active-high.
- bus_in  in  DATA_W  shared bus value as seen by this block.
- maddr_latch  in  1  MI strobe: load MAR from bus_in[ADDR_W-1:0].
- ram_latch  in  1  RI strobe: write bus_in to mem[MAR].
- ram_out  in  1  RO strobe: drive mem[MAR] onto the bus.
- bus_out  out  DATA_W  mem[MAR] when bus_out_en, else 0.
- bus_out_en  out  1  bus drive request.
- mar_q  out  ADDR_W  current MAR value, for debug LEDs.
- prog_mode  in  1  host request to enter/hold programming mode.
- prog_valid  in  1  host write request.
- prog_addr  in  ADDR_W  programming address.
- prog_data  in  DATA_W  programming data.
- prog_ready  out  1  block accepts programming writes.
- prog_count  out  ADDR_W+1  writes accepted since entering PROG.
- busy  out  1  high while in INIT or PROG; control logic must be held in reset or halted while busy.

Behaviour:
- Reset values: state=INIT, init_cnt=0, MAR=0, prog_count=0, prog_ready=0, bus_out_en=0, bus_out=0, busy=1.
- RAM contents are not reset directly; INIT overwrites them.
- State INIT: on each posedge, mem[init_cnt]<=0 and init_cnt<=init_cnt+1.
  - After the write at init_cnt=2**ADDR_W-1 (16 cycles), go to PROG if prog_mode=1, else RUN.
  - All control strobes and programming inputs are ignored in INIT.
- State RUN (busy=0, prog_ready=0):
  - maddr_latch=1: MAR<=bus_in[ADDR_W-1:0] at posedge.
  - ram_latch=1: mem[MAR]<=bus_in at posedge, using the pre-edge MAR. If maddr_latch and ram_latch are asserted together, the write goes to the old MAR and MAR also updates.
  - ram_out=1: bus_out_en=1 and bus_out=mem[MAR], combinational from registered MAR and an asynchronous RAM read, so the value is valid before the next posedge. A write and a read in the same cycle return the old data.
  - prog_mode=1 sampled at posedge: go to PROG; strobes on that same edge are still honoured.
- State PROG (busy=1, prog_ready=1):
  - prog_valid&prog_ready: mem[prog_addr]<=prog_data and prog_count<=prog_count+1, one write per cycle.
  - prog_count saturates at 2**(ADDR_W+1)-1.
  - Control strobes are ignored; bus_out_en=0.
  - prog_mode=0 sampled: go to RUN, MAR<=0, prog_count<=0. prog_ready drops on the same edge, and a coincident prog_valid is not accepted.
- Reset in any state, including mid-PROG or mid-INIT: immediate return to INIT with a full re-zero.
- Address wrap: all addresses are naturally ADDR_W bits; there is no out-of-range case.

Optional Feature:
- Macro: SAP_MEM_PARITY_EN.
- When defined:
  - Each RAM word stores an extra even-parity bit, written on INIT, RUN and PROG writes.
  - Extra input par_inject (1 bit): when high during a write, the stored parity bit is inverted.
  - Extra output par_err (1 bit, sticky): set at posedge when ram_out=1 in RUN and the recomputed parity of mem[MAR] mismatches.
  - par_err is cleared only by reset.
- When undefined: no parity storage, no par_inject or par_err ports; behaviour otherwise identical.

Decomposition:
- Shared package sap_pkg:
  - State enum MEM_INIT/MEM_RUN/MEM_PROG.
  - Constants SAP_ADDR_W=4 and SAP_DATA_W=8.
  - Control-word bit positions MI/RI/RO, shared with the control logic.
- One natural sub-module, sap_ram16x8: a register-array RAM with one synchronous write port and an asynchronous read port (parity bit included when the macro is set).
- The top level holds the FSM, MAR, the INIT counter and the programming handshake.

Test Plan:
- Reset, then idle 16 cycles -> busy=1 for exactly 16 cycles then 0; with maddr_latch stepping 0..15 and ram_out=1, every bus_out reads 0x00.
- prog_mode=1, then writes (addr,data)=(0,0x1E),(1,0x2F),(15,0x05) on consecutive cycles -> prog_count=3. Drop prog_mode -> mar_q=0, busy=0. MI with bus_in=0x0F, then RO -> bus_out=0x05, bus_out_en=1.
- RUN: MI bus_in=0x07, next cycle RI bus_in=0xA5, next cycle RO -> bus_out=0xA5. In the cycle with RI and RO together at MAR=7 holding 0x11, bus_out=0x11.
- Simultaneous MI+RI with MAR=3 and bus_in=0x09 -> mem[3]=0x09 and MAR=9; a subsequent RO reads mem[9].
- Reset asserted after 2 of 5 PROG writes -> INIT re-runs for 16 cycles and all 16 locations read 0x00.
- (SAP_MEM_PARITY_EN) PROG write to addr 4 with par_inject=1, then RUN MI=4 with RO -> par_err=1 at that edge and held until reset; a clean address read leaves par_err=0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: memory-stage state encoding, datapath widths and
// the control-word bit positions used by the control logic.
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  // Control-word layout, MSB first: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
  localparam int SAP_CW_W = 16;
  localparam int CW_HLT   = 15;
  localparam int CW_MI    = 14;
  localparam int CW_RI    = 13;
  localparam int CW_RO    = 12;

  typedef enum logic [1:0] {
    MEM_INIT = 2'd0,
    MEM_RUN  = 2'd1,
    MEM_PROG = 2'd2
  } mem_state_e;

endpackage

// File: rtl/sap_ram16x8.sv
// Register-array RAM: one synchronous write port, one asynchronous read port.
// With SAP_MEM_PARITY_EN defined, each word carries one extra stored parity bit.
module sap_ram16x8 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
`ifdef SAP_MEM_PARITY_EN
  ,
  input  logic              wpar,
  output logic              rpar
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

`ifdef SAP_MEM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      par_q[waddr] <= wpar;
    end
  end

  assign rpar = par_q[raddr];
`endif

endmodule

// File: rtl/sap_memory_unit.sv
// SAP-1 memory stage: MAR, zero-fill sequencer, host programming port and RAM.
// Optional stored even parity with sticky error flag under SAP_MEM_PARITY_EN.
module sap_memory_unit
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              maddr_latch,
  input  logic              ram_latch,
  input  logic              ram_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_out_en,
  output logic [ADDR_W-1:0] mar_q,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W:0]   prog_count,
  output logic              busy
`ifdef SAP_MEM_PARITY_EN
  ,
  input  logic              par_inject,
  output logic              par_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   PCNT_MAX  = {(ADDR_W + 1){1'b1}};

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_W-1:0] mar_d;
  logic [ADDR_W:0]   prog_count_q, prog_count_d;
  logic              prog_ready_q, prog_ready_d;
  logic              busy_q, busy_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    mar_d        = mar_q;
    prog_count_d = prog_count_q;
    ram_we       = 1'b0;
    ram_waddr    = mar_q;
    ram_wdata    = bus_in;

    case (state_q)
      MEM_INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdata  = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d      = prog_mode ? MEM_PROG : MEM_RUN;
          mar_d        = '0;
          prog_count_d = '0;
        end
      end
      MEM_RUN: begin
        // RI writes through the pre-edge MAR even when MI lands on the same edge
        ram_we = ram_latch;
        if (maddr_latch) begin
          mar_d = bus_in[ADDR_W-1:0];
        end
        if (prog_mode) begin
          state_d      = MEM_PROG;
          prog_count_d = '0;
        end
      end
      MEM_PROG: begin
        if (!prog_mode) begin
          state_d      = MEM_RUN;
          mar_d        = '0;
          prog_count_d = '0;
        end else if (prog_valid) begin
          ram_we    = 1'b1;
          ram_waddr = prog_addr;
          ram_wdata = prog_data;
          if (prog_count_q != PCNT_MAX) begin
            prog_count_d = prog_count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = MEM_INIT;
      end
    endcase

    if (reset) begin
      state_d      = MEM_INIT;
      init_cnt_d   = '0;
      mar_d        = '0;
      prog_count_d = '0;
      ram_we       = 1'b0;
    end

    busy_d       = (state_d != MEM_RUN);
    prog_ready_d = (state_d == MEM_PROG);
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    init_cnt_q   <= init_cnt_d;
    mar_q        <= mar_d;
    prog_count_q <= prog_count_d;
    prog_ready_q <= prog_ready_d;
    busy_q       <= busy_d;
  end

  assign bus_out_en = (state_q == MEM_RUN) && ram_out;
  assign bus_out    = bus_out_en ? ram_rdata : '0;
  assign prog_ready = prog_ready_q;
  assign prog_count = prog_count_q;
  assign busy       = busy_q;

`ifdef SAP_MEM_PARITY_EN
  logic ram_wpar;
  logic ram_rpar;
  logic par_err_q, par_err_d;

  // Injection is meaningless during zero-fill, so only RUN/PROG writes honour it
  assign ram_wpar = (^ram_wdata) ^ (par_inject && (state_q != MEM_INIT));

  always_comb begin
    par_err_d = par_err_q | (bus_out_en & ((^ram_rdata) != ram_rpar));
    if (reset) begin
      par_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

  sap_ram16x8 #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(mar_q),
    .rdata(ram_rdata)
`ifdef SAP_MEM_PARITY_EN
    ,
    .wpar (ram_wpar),
    .rpar (ram_rpar)
`endif
  );

endmodule
